uart_tx_frame: RTL and testbench

Parametrised UART transmitter: serialises one DATA_WIDTH-bit word per valid/ready handshake into an asynchronous serial frame. Each frame has a start bit, LSB-first data, an optional parity bit and 1 or 2 stop bits. Bit timing comes from an internal baud divider clocked by the system clock. It sits between a byte-stream producer (command packet builder, FIFO) and the TX pad.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_baud_tick.sv | 34 +++
 rtl/uart_tx_frame.sv | 157 +++++++++++++++
 tb/tb_uart_tx_frame.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, parity modes and baud-divider sizing.
// Used by the transmitter here and intended for reuse by the matching receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // System clock cycles per serial bit (integer division, truncating).
  function automatic int calc_cpb(input int clk_hz, input int bps);
    return clk_hz / bps;
  endfunction

  // Width of a counter running 0..cpb-1; never narrower than one bit.
  function automatic int cnt_width(input int cpb);
    return (cpb > 1) ? $clog2(cpb) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: runs 0..CPB-1 while enabled and flags the last cycle of each bit.
// A synchronous clear realigns the period to the start of a new frame.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CPB   = 4,
  parameter int CNT_W = cnt_width(CPB)
) (
  input  logic uart_clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CPB - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == LAST_CNT);
  assign o_tick = i_en && w_wrap;

  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || o_tick) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int SYS_CLK_FREQ = 50_000_000,
  parameter int BPS          = 115_200,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_MODE  = 0
) (
  input  logic                  uart_clk,
  input  logic                  rst_n,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_ready,
  output logic                  tx_out,
  output logic                  tx_busy,
  output logic                  tx_done,
  output logic [2:0]            dbg_state
);

  localparam int CPB   = calc_cpb(SYS_CLK_FREQ, BPS);
  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_WIDTH - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  if (CPB < 2) begin : g_bad_cpb
    $error("uart_tx_frame: SYS_CLK_FREQ/BPS must be at least 2");
  end
  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
    $error("uart_tx_frame: DATA_WIDTH must be 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (PARITY_MODE < PAR_NONE || PARITY_MODE > PAR_ODD) begin : g_bad_par
    $error("uart_tx_frame: PARITY_MODE must be 0, 1 or 2");
  end

  uart_state_e           r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [IDX_W-1:0]      r_bit_idx;
  logic                  r_stop_idx;
  logic                  r_tx_out;

  logic             w_tick;
  logic             w_accept;
  logic             w_done;
  logic             w_last_bit;
  logic             w_last_stop;
  logic [IDX_W-1:0] w_next_idx;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_ON = (PARITY_MODE == PAR_EVEN) || (PARITY_MODE == PAR_ODD);

  logic r_parity;
  logic w_parity;

  // Parity is taken from the word as it is captured, so later tx_data changes cannot affect it.
  assign w_parity = (PARITY_MODE == PAR_ODD) ? ~(^tx_data) : (^tx_data);
`endif

  assign w_last_bit  = (r_bit_idx == LAST_IDX);
  assign w_last_stop = (r_stop_idx == LAST_STOP);
  assign w_next_idx  = r_bit_idx + IDX_W'(1);
  assign w_done      = (r_state == STOP) && w_tick && w_last_stop;

  // Handshake: a word moves when tx_valid and tx_ready are both high at a rising edge.
  // tx_ready is high when idle and in the final cycle of a frame, so a producer that
  // keeps tx_valid high gets frames back to back with no idle bit between them.
  assign tx_ready  = (r_state == IDLE) || w_done;
  assign w_accept  = tx_valid && tx_ready;
  assign tx_busy   = (r_state != IDLE);
  assign tx_done   = w_done;
  assign tx_out    = r_tx_out;
  assign dbg_state = r_state;

  uart_baud_tick #(
    .CPB (CPB)
  ) u_baud (
    .uart_clk (uart_clk),
    .rst_n    (rst_n),
    .i_en     (tx_busy),
    .i_clr    (w_accept),
    .o_tick   (w_tick)
  );

  // tx_out is loaded together with the state, so the line level always matches the state's bit.
  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_tx_out   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_state    <= START;
      r_shift    <= tx_data;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_tx_out   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity   <= w_parity;
`endif
    end else if (w_tick) begin
      case (r_state)
        START: begin
          r_state  <= DATA;
          r_tx_out <= r_shift[0];
        end
        DATA: begin
          if (w_last_bit) begin
`ifdef UART_TX_PARITY_EN
            if (PAR_ON) begin
              r_state  <= PARITY;
              r_tx_out <= r_parity;
            end else begin
              r_state  <= STOP;
              r_tx_out <= 1'b1;
            end
`else
            r_state  <= STOP;
            r_tx_out <= 1'b1;
`endif
          end else begin
            r_bit_idx <= w_next_idx;
            r_tx_out  <= r_shift[w_next_idx];
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          r_state  <= STOP;
          r_tx_out <= 1'b1;
        end
`endif
        STOP: begin
          if (w_last_stop) begin
            r_state    <= IDLE;
            r_stop_idx <= 1'b0;
          end else begin
            r_stop_idx <= 1'b1;
          end
          r_tx_out <= 1'b1;
        end
        default: begin
          r_state  <= IDLE;
          r_tx_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: four instances (8N1, 2 stop bits, even and odd parity)
// at CPB=4; parity expectations follow UART_TX_PARITY_EN.
module tb_uart_tx_frame;
  import uart_pkg::*;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NP = 1;
`else
  localparam int NP = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] tx_valid_v;
  logic [7:0] tx_data_v [4];
  logic [3:0] tx_ready_v;
  logic [3:0] tx_out_v;
  logic [3:0] tx_busy_v;
  logic [3:0] tx_done_v;
  logic [2:0] dbg_v [4];

  int n_checks;
  int n_err;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_WIDTH(8), .SYS_CLK_FREQ(400), .BPS(100), .STOP_BITS(1), .PARITY_MODE(0)) dut_8n1 (
    .uart_clk(clk), .rst_n(rst_n), .tx_valid(tx_valid_v[0]), .tx_data(tx_data_v[0]),
    .tx_ready(tx_ready_v[0]), .tx_out(tx_out_v[0]), .tx_busy(tx_busy_v[0]),
    .tx_done(tx_done_v[0]), .dbg_state(dbg_v[0]));

  uart_tx_frame #(.DATA_WIDTH(8), .SYS_CLK_FREQ(400), .BPS(100), .STOP_BITS(2), .PARITY_MODE(0)) dut_8n2 (
    .uart_clk(clk), .rst_n(rst_n), .tx_valid(tx_valid_v[1]), .tx_data(tx_data_v[1]),
    .tx_ready(tx_ready_v[1]), .tx_out(tx_out_v[1]), .tx_busy(tx_busy_v[1]),
    .tx_done(tx_done_v[1]), .dbg_state(dbg_v[1]));

  uart_tx_frame #(.DATA_WIDTH(8), .SYS_CLK_FREQ(400), .BPS(100), .STOP_BITS(1), .PARITY_MODE(1)) dut_8e1 (
    .uart_clk(clk), .rst_n(rst_n), .tx_valid(tx_valid_v[2]), .tx_data(tx_data_v[2]),
    .tx_ready(tx_ready_v[2]), .tx_out(tx_out_v[2]), .tx_busy(tx_busy_v[2]),
    .tx_done(tx_done_v[2]), .dbg_state(dbg_v[2]));

  uart_tx_frame #(.DATA_WIDTH(8), .SYS_CLK_FREQ(400), .BPS(100), .STOP_BITS(1), .PARITY_MODE(2)) dut_8o1 (
    .uart_clk(clk), .rst_n(rst_n), .tx_valid(tx_valid_v[3]), .tx_data(tx_data_v[3]),
    .tx_ready(tx_ready_v[3]), .tx_out(tx_out_v[3]), .tx_busy(tx_busy_v[3]),
    .tx_done(tx_done_v[3]), .dbg_state(dbg_v[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a word at a falling edge; it is accepted at the following rising edge.
  task automatic start_frame(input int k, input logic [7:0] data, input bit hold);
    @(negedge clk);
    check($sformatf("k%0d ready before accept", k), tx_ready_v[k], 1'b1);
    tx_valid_v[k] = 1'b1;
    tx_data_v[k]  = data;
    @(posedge clk);
    #1;
    if (!hold) tx_valid_v[k] = 1'b0;
  endtask

  // Check every cycle of one frame; optionally pulse tx_valid with 0x00 at cycle pulse_at.
  task automatic check_frame(input int k, input logic [7:0] data, input int np, input logic pbit,
                             input int nstop, input int pulse_at, input string tag);
    int   f;
    int   b;
    logic exp_bit;
    f = (1 + 8 + np + nstop) * CPB;
    for (int c = 0; c < f; c++) begin
      @(negedge clk);
      b = c / CPB;
      if (b == 0)                exp_bit = 1'b0;
      else if (b <= 8)           exp_bit = data[b-1];
      else if (np == 1 && b == 9) exp_bit = pbit;
      else                       exp_bit = 1'b1;
      check($sformatf("%s c%0d tx_out", tag, c), tx_out_v[k], exp_bit);
      check($sformatf("%s c%0d tx_done", tag, c), tx_done_v[k], (c == f - 1));
      check($sformatf("%s c%0d tx_busy", tag, c), tx_busy_v[k], 1'b1);
      check($sformatf("%s c%0d tx_ready", tag, c), tx_ready_v[k], (c == f - 1));
      if (c == pulse_at) begin
        tx_data_v[k]  = 8'h00;
        tx_valid_v[k] = 1'b1;
      end
      if (c == pulse_at + 2) tx_valid_v[k] = 1'b0;
    end
  endtask

  task automatic check_idle(input int k, input string tag);
    @(negedge clk);
    check({tag, " idle tx_out"}, tx_out_v[k], 1'b1);
    check({tag, " idle tx_busy"}, tx_busy_v[k], 1'b0);
    check({tag, " idle tx_ready"}, tx_ready_v[k], 1'b1);
    check({tag, " idle tx_done"}, tx_done_v[k], 1'b0);
  endtask

  initial begin
    n_checks   = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    tx_valid_v = '0;
    for (int k = 0; k < 4; k++) tx_data_v[k] = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("k%0d reset tx_out", k), tx_out_v[k], 1'b1);
      check($sformatf("k%0d reset tx_busy", k), tx_busy_v[k], 1'b0);
      check($sformatf("k%0d reset tx_done", k), tx_done_v[k], 1'b0);
      check($sformatf("k%0d reset tx_ready", k), tx_ready_v[k], 1'b1);
      check($sformatf("k%0d reset state", k), dbg_v[k], IDLE);
    end
    rst_n = 1'b1;

    // 8N1, 0x55: alternating line, 40 cycles
    start_frame(0, 8'h55, 1'b0);
    check_frame(0, 8'h55, 0, 1'b0, 1, -10, "8n1 55");
    check_idle(0, "8n1 55");

    // two stop bits, 0xFF
    start_frame(1, 8'hFF, 1'b0);
    check_frame(1, 8'hFF, 0, 1'b0, 2, -10, "8n2 ff");
    check_idle(1, "8n2 ff");

    // 0x07 has three ones: even parity bit 1, odd parity bit 0
    start_frame(2, 8'h07, 1'b0);
    check_frame(2, 8'h07, NP, 1'b1, 1, -10, "even 07");
    check_idle(2, "even 07");
    start_frame(3, 8'h07, 1'b0);
    check_frame(3, 8'h07, NP, 1'b0, 1, -10, "odd 07");
    check_idle(3, "odd 07");

    // back to back: valid held, 0xA5 then 0x3C with no idle cycle
    start_frame(0, 8'hA5, 1'b1);
    tx_data_v[0] = 8'h3C;
    check_frame(0, 8'hA5, 0, 1'b0, 1, -10, "b2b a5");
    @(posedge clk);
    #1;
    tx_valid_v[0] = 1'b0;
    check_frame(0, 8'h3C, 0, 1'b0, 1, -10, "b2b 3c");
    check_idle(0, "b2b 3c");

    // tx_valid pulsed mid-frame with 0x00 is ignored
    start_frame(0, 8'hC3, 1'b0);
    check_frame(0, 8'hC3, 0, 1'b0, 1, 10, "pulse c3");
    check_idle(0, "pulse c3");

    // reset during data bit 3 of 0xF0 (line low there)
    start_frame(0, 8'hF0, 1'b0);
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      check($sformatf("rst pre c%0d tx_out", c), tx_out_v[0], 1'b0);
    end
    #2 rst_n = 1'b0;
    #1;
    check("rst async tx_out", tx_out_v[0], 1'b1);
    check("rst async tx_busy", tx_busy_v[0], 1'b0);
    check("rst async tx_ready", tx_ready_v[0], 1'b1);
    check("rst async tx_done", tx_done_v[0], 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rst hold c%0d tx_done", c), tx_done_v[0], 1'b0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      check($sformatf("rst post c%0d tx_out", c), tx_out_v[0], 1'b1);
      check($sformatf("rst post c%0d tx_done", c), tx_done_v[0], 1'b0);
      check($sformatf("rst post c%0d tx_busy", c), tx_busy_v[0], 1'b0);
    end
    start_frame(0, 8'h96, 1'b0);
    check_frame(0, 8'h96, 0, 1'b0, 1, -10, "after rst 96");
    check_idle(0, "after rst 96");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
